// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
// Holds the frame FSM state encoding, parity-type codes and the default word width.
package uart_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator for a WIDTH-bit word.
// Even parity is the XOR of all bits; odd parity is its inverse.
module parity_calc
  import uart_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] word,
  input  logic             par_typ,
  output logic             parity
);

  assign parity = (^word) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame controller: start bit, serializer-driven data bits, optional parity, stop bit.
// A DATA-phase watchdog aborts to STOP and raises a sticky err if ser_done never arrives.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = WIDTH + 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_data,
  input  logic             ser_done,
  output logic             ser_en,
  output logic             TX_OUT,
  output logic             Busy,
  output logic             frame_done,
  output logic             err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             par_en_reg, par_en_next;
  logic             par_typ_reg, par_typ_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             parity_bit;

  parity_calc #(
    .WIDTH(WIDTH)
  ) u_parity (
    .word    (data_reg),
    .par_typ (par_typ_reg),
    .parity  (parity_bit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      par_en_reg  <= par_en_next;
      par_typ_reg <= par_typ_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    par_en_next  = par_en_reg;
    par_typ_next = par_typ_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (DATA_VALID) begin
          data_next    = P_DATA;
          par_en_next  = PAR_EN;
          par_typ_next = PAR_TYP;
          state_next   = START;
        end
      end
      START: begin
        cnt_next   = '0;
        state_next = DATA;
      end
      DATA: begin
        // cnt_reg counts DATA cycles already spent; ser_done wins over the timeout.
        if (ser_done) begin
          state_next = par_en_reg ? PARITY : STOP;
        end else if (cnt_reg == LAST_CNT) begin
          err_next   = 1'b1;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      PARITY: state_next = STOP;
      STOP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    TX_OUT     = 1'b1;
    Busy       = 1'b1;
    ser_en     = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:   Busy = 1'b0;
      START:  TX_OUT = 1'b0;
      DATA: begin
        ser_en = 1'b1;
        TX_OUT = ser_data;
      end
      PARITY: TX_OUT = parity_bit;
      STOP:   frame_done = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

  assign err = err_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized scoreboard bench for uart_tx_ctrl: stimulus pushes whole expected frames,
// a negedge monitor pops and compares every line cycle; a serializer model feeds data bits.
module tb_uart_tx_ctrl;

  localparam int W  = 8;
  localparam int TO = 10;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID, PAR_EN, PAR_TYP;
  logic         ser_data, ser_done;
  logic         ser_en, TX_OUT, Busy, frame_done, err;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data), .ser_done(ser_done),
    .ser_en(ser_en), .TX_OUT(TX_OUT), .Busy(Busy), .frame_done(frame_done), .err(err)
  );

  typedef struct {
    logic [W-1:0] word;
    logic         pe, pt;
    int           done_at;
    logic [31:0]  tx, sen;
    int           len;
    bit           timeout;
  } frame_t;

  typedef struct {
    logic [W-1:0] word;
    int           done_at;
  } ser_t;

  frame_t exp_q[$];
  ser_t   ser_q[$];
  int     checks = 0, errors = 0;
  int     frames_sent = 0, frames_seen = 0;
  bit     mon_en = 1'b0;
  bit     err_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected line sequence for one frame, from the frame rules alone.
  function automatic frame_t build(input logic [W-1:0] w, input logic pe, input logic pt,
                                   input int done_at);
    frame_t f;
    int n, p;
    f.word = w; f.pe = pe; f.pt = pt; f.done_at = done_at;
    f.tx = '0; f.sen = '0;
    f.timeout = (done_at == 0) || (done_at > TO);
    n = f.timeout ? TO : done_at;
    p = 0;
    f.tx[p] = 1'b0; p++;
    for (int k = 1; k <= n; k++) begin
      f.tx[p]  = (k <= W) ? w[k-1] : 1'b1;
      f.sen[p] = 1'b1;
      p++;
    end
    if (pe && !f.timeout) begin
      f.tx[p] = (($countones(w) % 2) == 1) ^ pt;
      p++;
    end
    f.tx[p] = 1'b1; p++;
    f.len = p;
    return f;
  endfunction

  // Accept in an idle cycle, then fill the busy cycles with junk inputs that must be ignored.
  task automatic send(input logic [W-1:0] w, input logic pe, input logic pt,
                      input int done_at, input bit hold);
    frame_t f;
    ser_t   s;
    f = build(w, pe, pt, done_at);
    @(posedge CLK); #1;
    DATA_VALID = 1'b1; P_DATA = w; PAR_EN = pe; PAR_TYP = pt;
    exp_q.push_back(f);
    s.word = w; s.done_at = done_at;
    ser_q.push_back(s);
    frames_sent++;
    for (int i = 0; i < f.len; i++) begin
      @(posedge CLK); #1;
      DATA_VALID = hold ? 1'b1 : 1'($urandom_range(0, 1));
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom_range(0, 1));
      PAR_TYP    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      DATA_VALID = 1'b0;
      P_DATA     = W'($urandom);
    end
  endtask

  task automatic reset_mid_frame(input logic [W-1:0] w);
    ser_t s;
    @(posedge CLK); #1;
    DATA_VALID = 1'b1; P_DATA = w; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    exp_q.push_back(build(w, 1'b1, 1'b0, 9));
    s.word = w; s.done_at = 9;
    ser_q.push_back(s);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      DATA_VALID = 1'b0;
    end
    #2;
    mon_en = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_mid_tx_out", TX_OUT, 1);
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_ser_en", ser_en, 0);
    chk("rst_mid_frame_done", frame_done, 0);
    chk("rst_mid_err", err, 0);
    exp_q.delete();
    ser_q.delete();
    err_model = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    $display("reset applied mid-frame, word=%h aborted", w);
    @(posedge CLK); #1;
    mon_en = 1'b1;
  endtask

  // Serializer model: LSB-first bits, ser_done on the done_at-th consecutive ser_en cycle.
  int   sz_k = 0;
  ser_t sz_cur;
  initial begin
    ser_data = 1'b0;
    ser_done = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (RST || !ser_en) begin
        sz_k     = 0;
        ser_data = 1'($urandom_range(0, 1));
        ser_done = 1'($urandom_range(0, 1));
      end else begin
        if (sz_k == 0) begin
          if (ser_q.size() > 0) sz_cur = ser_q.pop_front();
          else begin
            sz_cur.word = '0;
            sz_cur.done_at = 9;
          end
        end
        sz_k++;
        ser_data = (sz_k <= W) ? sz_cur.word[sz_k-1] : 1'b1;
        ser_done = (sz_cur.done_at != 0) && (sz_k == sz_cur.done_at);
      end
    end
  end

  frame_t mon_cur;
  int     mon_idx = 0;
  bit     mon_in_frame = 1'b0;
  logic   mon_exp_err;
  initial begin
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        mon_in_frame = 1'b0;
        continue;
      end
      if (!mon_in_frame && Busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got Busy=1 expected no frame at t=%0t", $time);
        end else begin
          mon_cur      = exp_q.pop_front();
          mon_in_frame = 1'b1;
          mon_idx      = 0;
        end
      end
      if (mon_in_frame) begin
        mon_exp_err = err_model | (mon_cur.timeout && (mon_idx == mon_cur.len - 1));
        chk("tx_out", TX_OUT, mon_cur.tx[mon_idx]);
        chk("ser_en", ser_en, mon_cur.sen[mon_idx]);
        chk("busy", Busy, 1);
        chk("frame_done", frame_done, mon_idx == mon_cur.len - 1);
        chk("err", err, mon_exp_err);
        mon_idx++;
        if (mon_idx == mon_cur.len) begin
          mon_in_frame = 1'b0;
          if (mon_cur.timeout) err_model = 1'b1;
          frames_seen++;
          $display("frame %0d word=%h par_en=%0d par_typ=%0d done_at=%0d len=%0d timeout=%0d",
                   frames_seen, mon_cur.word, mon_cur.pe, mon_cur.pt, mon_cur.done_at,
                   mon_cur.len, mon_cur.timeout);
        end
      end else begin
        chk("idle_tx_out", TX_OUT, 1);
        chk("idle_ser_en", ser_en, 0);
        chk("idle_frame_done", frame_done, 0);
        chk("idle_err", err, err_model);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by t=200000");
    $fatal(1, "watchdog expired");
  end

  int r, d;
  initial begin
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #2;
    chk("reset_tx_out", TX_OUT, 1);
    chk("reset_busy", Busy, 0);
    chk("reset_ser_en", ser_en, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_err", err, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    mon_en = 1'b1;

    send(8'hA5, 1'b1, 1'b0, 9, 1'b0);
    send(8'h01, 1'b1, 1'b1, 9, 1'b0);
    send(8'h01, 1'b0, 1'b1, 9, 1'b0);
    for (int i = 0; i < 4; i++)
      send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9, 1'b1);
    idle(3);

    send(W'($urandom), 1'b1, 1'($urandom_range(0, 1)), 0, 1'b0);
    send(W'($urandom), 1'b1, 1'b0, 9, 1'b0);
    send(W'($urandom), 1'b0, 1'b1, 9, 1'b0);

    reset_mid_frame(W'($urandom));
    send(W'($urandom), 1'b1, 1'b0, 9, 1'b0);
    send(W'($urandom), 1'b1, 1'($urandom_range(0, 1)), TO, 1'b0);

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        2:       d = TO;
        3:       d = 0;
        4:       d = $urandom_range(1, 8);
        5:       d = $urandom_range(TO + 1, TO + 4);
        default: d = 9;
      endcase
      send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
           1'($urandom_range(0, 1)));
    end
    idle(4);

    chk("pending_frames", exp_q.size(), 0);
    chk("frames_seen", frames_seen, frames_sent);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data bits per frame.
REQ-002 The block SHALL have parameter TIMEOUT, default WIDTH+2, meaning the maximum DATA-state cycles without ser_done before abort.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port P_DATA, input, WIDTH bits: the parallel word to transmit.
REQ-007 The block SHALL have port DATA_VALID, input, 1 bit: P_DATA valid request.
REQ-008 The block SHALL have port PAR_EN, input, 1 bit: parity bit enable, sampled on accept.
REQ-009 The block SHALL have port PAR_TYP, input, 1 bit: 0 = even, 1 = odd, sampled on accept.
REQ-010 The block SHALL have port ser_data, input, 1 bit: current bit from the serializer.
REQ-011 The block SHALL have port ser_done, input, 1 bit: serializer finished all WIDTH bits.
REQ-012 The block SHALL have port ser_en, output, 1 bit: serializer shift enable.
REQ-013 The block SHALL have port TX_OUT, output, 1 bit: the serial line, idle high.
REQ-014 The block SHALL have port Busy, output, 1 bit: frame in progress.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on frame completion.
REQ-016 The block SHALL have port err, output, 1 bit: sticky flag set on serializer timeout.

Function
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with DATA_VALID=1, the block SHALL capture P_DATA, PAR_EN and PAR_TYP and enter START next cycle; DATA_VALID=0 stays in IDLE.
REQ-019 DATA_VALID while Busy=1 SHALL be ignored; there is no queuing.
REQ-020 START SHALL last exactly 1 cycle with TX_OUT=0, then go to DATA.
REQ-021 In DATA, ser_en SHALL be 1 and TX_OUT SHALL equal ser_data; ser_en SHALL be 0 in every other state.
REQ-022 DATA SHALL exit on ser_done=1: to PARITY if captured PAR_EN=1, else to STOP.
REQ-023 The parity bit SHALL be the XOR of the captured word; PAR_TYP=1 inverts it. PARITY SHALL last 1 cycle with TX_OUT=parity bit, then go to STOP.
REQ-024 STOP SHALL last 1 cycle with TX_OUT=1 and frame_done=1, then go to IDLE unconditionally, guaranteeing at least 1 idle cycle between frames.
REQ-025 Busy SHALL be 0 in IDLE and 1 in all other states; TX_OUT SHALL be 1 in IDLE.
REQ-026 A DATA-state cycle counter, clog2(TIMEOUT+1) bits wide, SHALL clear on DATA entry.
REQ-027 When the counter reaches TIMEOUT without ser_done, the block SHALL set err, skip PARITY and go to STOP.
REQ-028 err SHALL clear only on reset.
REQ-029 ser_done arriving on the same cycle the counter reaches TIMEOUT SHALL take priority: normal exit, err unchanged.
REQ-030 ser_done outside DATA SHALL be ignored.
REQ-031 Outputs SHALL be decoded from the state register and ser_data only, with no combinational path from DATA_VALID.

Reset
REQ-032 RST=1 SHALL force, asynchronously: state IDLE, TX_OUT=1, Busy=0, ser_en=0, frame_done=0, err=0, captured data=0, counter=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame; after release the line stays high until a new DATA_VALID.

Structure
REQ-034 Package uart_pkg SHALL hold the state enum typedef, the parity-type constants PAR_EVEN/PAR_ODD and the default WIDTH.
REQ-035 One sub-module, parity_calc, SHALL compute the parity from (WIDTH-bit word, PAR_TYP); it is combinational.

Verification
The bench serializer model asserts ser_done on the 9th consecutive ser_en cycle.
REQ-036 IDLE, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, DATA_VALID pulse -> TX_OUT: 0, model bits, parity=0, 1; Busy high for 12 cycles; one frame_done pulse.
REQ-037 P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> parity cycle TX_OUT=0; PAR_EN=0 -> PARITY skipped, Busy high for 11 cycles.
REQ-038 DATA_VALID held high continuously -> frames separated by exactly 1 IDLE cycle with TX_OUT=1; mid-frame P_DATA changes do not affect the frame in flight.
REQ-039 Model never asserts ser_done -> after TIMEOUT=10 DATA cycles err=1 and STOP is entered; err persists across later good frames until RST.
REQ-040 RST pulsed during DATA -> same cycle: TX_OUT=1, Busy=0, ser_en=0, state IDLE; the next DATA_VALID yields a clean frame.
REQ-041 ser_done coincident with the counter reaching TIMEOUT -> normal exit and err stays 0.
